imm_extend_pipe: RTL

Parametrised, registered immediate-extension unit for the MIPS datapath. It takes an IN_W-bit immediate and produces an OUT_W-bit operand in one of four modes: sign-extend, zero-extend, upper-placement (LUI) and byte sign-extend (LB). Results pass through a DEPTH-entry FIFO with valid/ready handshakes on both sides. It sits between instruction decode and the ALU-operand mux and replaces the purely combinational halfword sign extender.

---
 rtl/imm_ext_pkg.sv | 20 ++
 rtl/imm_ext_core.sv | 39 +++
 rtl/imm_extend_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for immediate extension. The decode, ALU-control and
// extension blocks all use these mode encodings.
//   imm_mode_t : 2-bit extension mode selector
//   MODE_SEXT  : sign-extend the full immediate
//   MODE_ZEXT  : zero-extend the full immediate
//   MODE_UPPER : place the immediate in the top bits (LUI)
//   MODE_BSEXT : sign-extend the low byte only (LB)
// -----------------------------------------------------------------------------
package imm_ext_pkg;

    typedef logic [1:0] imm_mode_t;

    localparam imm_mode_t MODE_SEXT  = 2'b00;
    localparam imm_mode_t MODE_ZEXT  = 2'b01;
    localparam imm_mode_t MODE_UPPER = 2'b10;
    localparam imm_mode_t MODE_BSEXT = 2'b11;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// -----------------------------------------------------------------------------
// imm_ext_core
// Purely combinational immediate extender.
//   i_imm  [IN_W-1:0]  raw immediate
//   i_mode [1:0]       extension mode (MODE_*)
//   o_data [OUT_W-1:0] extended operand
// When OUT_W == IN_W the sign, zero and upper modes degenerate to a pass-through;
// the size casts and a zero-distance shift handle that without special cases.
// -----------------------------------------------------------------------------
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  i_imm,
    input  imm_mode_t        i_mode,
    output logic [OUT_W-1:0] o_data
);

    localparam int SHIFT = OUT_W - IN_W;

    logic [7:0] w_byte;

    assign w_byte = i_imm[7:0];

    // Mode mux: every 2-bit code is a legal mode.
    always_comb begin
        o_data = '0;
        case (i_mode)
            MODE_SEXT:  o_data = OUT_W'($signed(i_imm));
            MODE_ZEXT:  o_data = OUT_W'(i_imm);
            MODE_UPPER: o_data = OUT_W'(i_imm) << SHIFT;
            MODE_BSEXT: o_data = OUT_W'($signed(w_byte));
            default:    o_data = '0;
        endcase
    end

endmodule : imm_ext_core

// File: rtl/imm_extend_pipe.sv
// -----------------------------------------------------------------------------
// imm_extend_pipe
// Registered immediate-extension unit: extends the immediate at acceptance and
// queues the result in a DEPTH-entry FIFO with valid/ready on both sides.
//   Clk       clock, rising edge
//   Rst       synchronous active-low reset; flushes all queued entries
//   InValid   producer has an immediate
//   InReady   an input can be accepted this cycle (registered occupancy only)
//   InImm     raw immediate, IN_W bits
//   InMode    extension mode (MODE_*)
//   OutValid  FIFO head is valid
//   OutReady  consumer takes the head this cycle
//   OutData   extended result at the head
//   OutNeg    sign bit of the head result, stored with the entry
//   Count     current occupancy
// -----------------------------------------------------------------------------
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [IN_W-1:0]          InImm,
    input  imm_mode_t                InMode,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [OUT_W-1:0]         OutData,
    output logic                     OutNeg,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (IN_W < 8) begin : g_bad_in_w_small
            $error("imm_extend_pipe: IN_W must be at least 8");
        end
        if (IN_W > OUT_W) begin : g_bad_in_w_large
            $error("imm_extend_pipe: IN_W must not exceed OUT_W");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("imm_extend_pipe: DEPTH must be a power of two, at least 2");
        end
    endgenerate

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic             r_neg [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .i_imm  (InImm),
        .i_mode (InMode),
        .o_data (w_ext)
    );

    // A full FIFO refuses input even when it is popping in the same cycle,
    // so InReady never depends on OutReady.
    assign InReady  = Rst && (r_count < CW'(DEPTH));
    assign OutValid = (r_count != CW'(0));
    assign w_push   = InValid && InReady;
    assign w_pop    = OutValid && OutReady;

    // Storage is cleared on reset, so the head reads as zero until refilled.
    assign OutData  = r_mem[r_rd_ptr];
    assign OutNeg   = r_neg[r_rd_ptr];
    assign Count    = r_count;

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
                r_neg[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ext;
                r_neg[r_wr_ptr] <= w_ext[OUT_W-1];
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : imm_extend_pipe
